// File: rtl/gpu_wb_pkg.sv
// Shared types and constants for the GPU writeback drain.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Holds the drain FSM state encoding, the latched entry record and the
// default geometry that the entry record is sized from.
package gpu_wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_VEC_SIZE   = 4;
    localparam int WB_TAG_WIDTH  = 8;
    localparam int WB_ADDR_WIDTH = 32;

    // Byte stride between consecutive lanes of a memory writeback.
    localparam int BYTES_PER_LANE = WB_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RF_WR    = 2'd1,
        S_MEM_BEAT = 2'd2,
        S_DONE     = 2'd3
    } drain_state_t;

    // One popped writeback entry, held for the whole time it is in flight.
    typedef struct packed {
        logic [WB_DATA_WIDTH*WB_VEC_SIZE-1:0] data;
        logic [WB_TAG_WIDTH-1:0]              tag;
        logic [3:0]                           dest_reg;
        logic                                 is_vector;
        logic                                 write_mem;
        logic [WB_ADDR_WIDTH-1:0]             addr;
    } wb_entry_t;

endpackage

// File: rtl/gpu_wb_mem_seq.sv
// Memory lane sequencer: issues one write beat per lane and watches for ack timeouts.
// Latency: first beat in the cycle after start; done/err are combinational with the closing ack or timeout.
// Backpressure: each beat holds address/data stable until i_mem_ack; aborts after TIMEOUT_CYCLES without ack.
//
// Ports: start (pulse on the pop edge that enters the memory phase), active
// (memory phase in progress), is_vector/data/base (latched entry), mem_ack in;
// mem_req/mem_addr/mem_wdata beat outputs; done (phase finished this cycle)
// and err (finished by timeout) out.
module gpu_wb_mem_seq
    import gpu_wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int VEC_SIZE       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           active,
    input  logic                           is_vector,
    input  logic [DATA_WIDTH*VEC_SIZE-1:0] data,
    input  logic [ADDR_WIDTH-1:0]          base,
    input  logic                           mem_ack,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    output logic                           done,
    output logic                           err
);

    localparam int BEAT_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [BEAT_W-1:0] beat;
    logic [TCNT_W-1:0] tcnt;
    logic              last_beat;
    logic              timed_out;

    // A scalar entry only ever sends lane 0.
    assign last_beat = is_vector ? (beat == BEAT_W'(VEC_SIZE - 1)) : (beat == '0);

    // An ack arriving in the final allowed cycle still counts as success.
    assign timed_out = active && !mem_ack && (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

    assign done = active && ((mem_ack && last_beat) || timed_out);
    assign err  = timed_out;

    assign mem_req   = active;
    assign mem_addr  = active ? (base + ADDR_WIDTH'(beat) * ADDR_WIDTH'(BYTES_PER_LANE)) : '0;
    assign mem_wdata = active ? data[beat*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            beat <= '0;
            tcnt <= '0;
        end else if (active) begin
            if (mem_ack) begin
                tcnt <= '0;
                if (!last_beat) begin
                    beat <= beat + 1'b1;
                end
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_wb_drain.sv
// Writeback drain: pops result entries and commits them to the register file or memory.
// Latency: register entry RF write at pop+1, done at pop+2; memory entry done one cycle after the last ack.
// Backpressure: pops only in IDLE with valid and no stall; memory beats wait for ack up to TIMEOUT_CYCLES.
//
// Ports: i_wb_* head entry of the writeback buffer, o_wb_req pop strobe,
// i_stall pop inhibit; o_rf_* masked vector register write; o_mem_*/i_mem_ack
// per-lane memory beats; o_done_* completion pulse for the scoreboard;
// o_busy, o_mem_error (sticky timeout) and o_retire_count status.
module gpu_wb_drain
    import gpu_wb_pkg::*;
#(
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int VEC_SIZE       = WB_VEC_SIZE,
    parameter int TAG_WIDTH      = WB_TAG_WIDTH,
    parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_wb_valid,
    input  logic [DATA_WIDTH*VEC_SIZE-1:0] i_wb_data,
    input  logic [TAG_WIDTH-1:0]           i_wb_tag,
    input  logic [3:0]                     i_wb_dest_reg,
    input  logic                           i_wb_is_vector,
    input  logic                           i_wb_write_mem,
    input  logic [ADDR_WIDTH-1:0]          i_wb_mem_addr,
    output logic                           o_wb_req,
    input  logic                           i_stall,
    output logic                           o_rf_we,
    output logic [3:0]                     o_rf_addr,
    output logic [VEC_SIZE-1:0]            o_rf_lane_mask,
    output logic [DATA_WIDTH*VEC_SIZE-1:0] o_rf_wdata,
    output logic                           o_mem_req,
    output logic [ADDR_WIDTH-1:0]          o_mem_addr,
    output logic [DATA_WIDTH-1:0]          o_mem_wdata,
    input  logic                           i_mem_ack,
    output logic                           o_done_valid,
    output logic [TAG_WIDTH-1:0]           o_done_tag,
    output logic [3:0]                     o_done_dest_reg,
    output logic                           o_done_err,
    output logic                           o_busy,
    output logic                           o_mem_error,
    output logic [15:0]                    o_retire_count
);

    drain_state_t state;
    wb_entry_t    entry;
    logic         err_pending;
    logic         mem_error;
    logic [15:0]  retire_count;

    logic         pop;
    logic         seq_active;
    logic         seq_done;
    logic         seq_err;

    // Gated by rst so the buffer is never popped while reset is held.
    assign pop      = (state == S_IDLE) && i_wb_valid && !i_stall && !rst;
    assign o_wb_req = pop;

    assign seq_active = (state == S_MEM_BEAT) && entry.write_mem;

    gpu_wb_mem_seq #(
        .DATA_WIDTH     (DATA_WIDTH),
        .VEC_SIZE       (VEC_SIZE),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_mem_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (pop && i_wb_write_mem),
        .active    (seq_active),
        .is_vector (entry.is_vector),
        .data      (entry.data),
        .base      (entry.addr),
        .mem_ack   (i_mem_ack),
        .mem_req   (o_mem_req),
        .mem_addr  (o_mem_addr),
        .mem_wdata (o_mem_wdata),
        .done      (seq_done),
        .err       (seq_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            entry        <= '0;
            err_pending  <= 1'b0;
            mem_error    <= 1'b0;
            retire_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        entry.data      <= i_wb_data;
                        entry.tag       <= i_wb_tag;
                        entry.dest_reg  <= i_wb_dest_reg;
                        entry.is_vector <= i_wb_is_vector;
                        entry.write_mem <= i_wb_write_mem;
                        entry.addr      <= i_wb_mem_addr;
                        err_pending     <= 1'b0;
                        state           <= i_wb_write_mem ? S_MEM_BEAT : S_RF_WR;
                    end
                end
                S_RF_WR: begin
                    state <= S_DONE;
                end
                S_MEM_BEAT: begin
                    if (seq_done) begin
                        state <= S_DONE;
                        if (seq_err) begin
                            err_pending <= 1'b1;
                            mem_error   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    retire_count <= retire_count + 16'd1;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Register-file write: one cycle, data and mask only driven while enabled.
    assign o_rf_we        = (state == S_RF_WR);
    assign o_rf_addr      = o_rf_we ? entry.dest_reg : 4'd0;
    assign o_rf_lane_mask = !o_rf_we ? '0 : (entry.is_vector ? '1 : VEC_SIZE'(1));
    assign o_rf_wdata     = o_rf_we ? entry.data : '0;

    // Completion pulse, shared by register and memory entries.
    assign o_done_valid    = (state == S_DONE);
    assign o_done_tag      = o_done_valid ? entry.tag : '0;
    assign o_done_dest_reg = o_done_valid ? entry.dest_reg : 4'd0;
    assign o_done_err      = o_done_valid && err_pending;

    assign o_busy         = (state != S_IDLE);
    assign o_mem_error    = mem_error;
    assign o_retire_count = retire_count;

endmodule

// File: tb/tb_gpu_wb_drain.sv
// Testbench for gpu_wb_drain: directed vector table, multi-cycle corner sequences, random entries.
// Latency: n/a.
// Backpressure: bench drives ack delays and stalls from its own entry model.
module tb_gpu_wb_drain;

    localparam int T = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_wb_valid;
    logic [127:0] i_wb_data;
    logic [7:0]   i_wb_tag;
    logic [3:0]   i_wb_dest_reg;
    logic         i_wb_is_vector;
    logic         i_wb_write_mem;
    logic [31:0]  i_wb_mem_addr;
    logic         o_wb_req;
    logic         i_stall;
    logic         o_rf_we;
    logic [3:0]   o_rf_addr;
    logic [3:0]   o_rf_lane_mask;
    logic [127:0] o_rf_wdata;
    logic         o_mem_req;
    logic [31:0]  o_mem_addr;
    logic [31:0]  o_mem_wdata;
    logic         i_mem_ack;
    logic         o_done_valid;
    logic [7:0]   o_done_tag;
    logic [3:0]   o_done_dest_reg;
    logic         o_done_err;
    logic         o_busy;
    logic         o_mem_error;
    logic [15:0]  o_retire_count;

    gpu_wb_drain #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .i_wb_valid(i_wb_valid), .i_wb_data(i_wb_data), .i_wb_tag(i_wb_tag),
        .i_wb_dest_reg(i_wb_dest_reg), .i_wb_is_vector(i_wb_is_vector),
        .i_wb_write_mem(i_wb_write_mem), .i_wb_mem_addr(i_wb_mem_addr),
        .o_wb_req(o_wb_req), .i_stall(i_stall),
        .o_rf_we(o_rf_we), .o_rf_addr(o_rf_addr), .o_rf_lane_mask(o_rf_lane_mask),
        .o_rf_wdata(o_rf_wdata),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack),
        .o_done_valid(o_done_valid), .o_done_tag(o_done_tag),
        .o_done_dest_reg(o_done_dest_reg), .o_done_err(o_done_err),
        .o_busy(o_busy), .o_mem_error(o_mem_error), .o_retire_count(o_retire_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state kept at entry level.
    int   exp_retire    = 0;
    logic exp_mem_error = 1'b0;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   tag;
        logic [3:0]   dest;
        logic         vec;
        logic         mem;
        logic [31:0]  addr;
        int           ack_delay;
        int           pre_stall;
        bit           hold_valid;
        bit           stall_fl;
        logic [3:0]   exp_mask;
        int           exp_beats;
        logic [31:0]  exp_last;
        logic         exp_err;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven 2 ns after the rising edge, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t mkv(input logic [127:0] data, input logic [7:0] tag, input logic [3:0] dest,
                                 input logic vec, input logic mem, input logic [31:0] addr,
                                 input int ack_delay, input int pre_stall, input bit hold_valid,
                                 input bit stall_fl, input logic [3:0] exp_mask, input int exp_beats,
                                 input logic [31:0] exp_last, input logic exp_err);
        vec_t v;
        v.data = data; v.tag = tag; v.dest = dest; v.vec = vec; v.mem = mem; v.addr = addr;
        v.ack_delay = ack_delay; v.pre_stall = pre_stall; v.hold_valid = hold_valid;
        v.stall_fl = stall_fl; v.exp_mask = exp_mask; v.exp_beats = exp_beats;
        v.exp_last = exp_last; v.exp_err = exp_err;
        return v;
    endfunction

    // Presents one entry and follows it to retirement, checking every cycle
    // against what the entry rules predict. Returns a summary of what was seen.
    task automatic do_entry(input vec_t e, output int beats, output logic [31:0] last_addr,
                            output logic [3:0] mask, output logic err);
        int          nb;
        bit          aborted;
        logic [31:0] ea;
        logic [31:0] ed;
        beats = 0; last_addr = '0; mask = '0; err = 1'b0; aborted = 1'b0;
        nb = e.vec ? 4 : 1;

        i_wb_valid = 1'b1; i_wb_data = e.data; i_wb_tag = e.tag; i_wb_dest_reg = e.dest;
        i_wb_is_vector = e.vec; i_wb_write_mem = e.mem; i_wb_mem_addr = e.addr;
        for (int s = 0; s < e.pre_stall; s++) begin
            i_stall = 1'b1;
            #1;
            check("stall_no_req", o_wb_req, 1'b0);
            check("stall_idle", o_busy, 1'b0);
            tick();
        end
        i_stall = 1'b0;
        #1;
        check("pop_req", o_wb_req, 1'b1);
        tick();

        // Scramble the buffer head after the pop: the entry must already be latched.
        i_wb_valid = e.hold_valid; i_wb_data = ~e.data; i_wb_tag = ~e.tag;
        i_wb_dest_reg = ~e.dest; i_wb_mem_addr = ~e.addr;
        i_stall = e.stall_fl;

        if (!e.mem) begin
            #1;
            check("rf_we", o_rf_we, 1'b1);
            check("rf_addr", o_rf_addr, e.dest);
            check("rf_mask", o_rf_lane_mask, e.vec ? 4'hF : 4'h1);
            check("rf_wdata", o_rf_wdata, e.data);
            check("rf_no_mem", o_mem_req, 1'b0);
            check("rf_no_done", o_done_valid, 1'b0);
            check("rf_no_pop", o_wb_req, 1'b0);
            mask = o_rf_lane_mask;
            tick();
        end else begin
            for (int b = 0; b < nb && !aborted; b++) begin
                ea = e.addr + 32'(b * 4);
                ed = e.data[b*32 +: 32];
                for (int w = 0; w < T; w++) begin
                    i_mem_ack = (w == e.ack_delay);
                    #1;
                    check("mem_req", o_mem_req, 1'b1);
                    check("mem_addr", o_mem_addr, ea);
                    check("mem_wdata", o_mem_wdata, ed);
                    check("mem_no_rf", o_rf_we, 1'b0);
                    check("mem_no_done", o_done_valid, 1'b0);
                    check("mem_no_pop", o_wb_req, 1'b0);
                    if (w == 0) begin
                        beats++;
                        last_addr = o_mem_addr;
                    end
                    tick();
                    i_mem_ack = 1'b0;
                    if (w == e.ack_delay) break;
                    if (w == T - 1) aborted = 1'b1;
                end
            end
        end

        if (aborted) exp_mem_error = 1'b1;
        #1;
        check("done_valid", o_done_valid, 1'b1);
        check("done_tag", o_done_tag, e.tag);
        check("done_dest", o_done_dest_reg, e.dest);
        check("done_err", o_done_err, aborted);
        check("done_no_mem", o_mem_req, 1'b0);
        check("done_no_rf", o_rf_we, 1'b0);
        check("done_no_pop", o_wb_req, 1'b0);
        check("done_busy", o_busy, 1'b1);
        check("done_mem_error", o_mem_error, exp_mem_error);
        err = o_done_err;
        exp_retire++;
        i_wb_valid = 1'b0;
        i_stall = 1'b0;
        tick();
        #1;
        check("idle_busy", o_busy, 1'b0);
        check("idle_no_done", o_done_valid, 1'b0);
        check("retire_count", o_retire_count, 16'(exp_retire));
        check("idle_mem_error", o_mem_error, exp_mem_error);
    endtask

    vec_t        tbl[8];
    vec_t        rv;
    int          beats;
    logic [31:0] last_addr;
    logic [3:0]  mask;
    logic        err;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mkv({96'h0, 32'hDEADBEEF}, 8'h11, 4'd5, 1'b0, 1'b0, 32'h0,
                     0, 0, 1'b0, 1'b0, 4'h1, 0, 32'h0, 1'b0);
        tbl[1] = mkv({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h22, 4'd3, 1'b1, 1'b1, 32'h1000,
                     2, 0, 1'b0, 1'b0, 4'h0, 4, 32'h100C, 1'b0);
        tbl[2] = mkv({96'h0, 32'h55}, 8'h33, 4'd7, 1'b0, 1'b1, 32'hFFFFFFFC,
                     1, 0, 1'b0, 1'b0, 4'h0, 1, 32'hFFFFFFFC, 1'b0);
        tbl[3] = mkv({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 8'h44, 4'd8, 1'b1, 1'b1, 32'hFFFFFFFC,
                     0, 0, 1'b0, 1'b0, 4'h0, 4, 32'h00000008, 1'b0);
        tbl[4] = mkv({32'hC3, 32'hC2, 32'hC1, 32'hC0}, 8'h4A, 4'd1, 1'b1, 1'b1, 32'h4000,
                     100, 0, 1'b0, 1'b0, 4'h0, 1, 32'h4000, 1'b1);
        tbl[5] = mkv({32'h4, 32'h3, 32'h2, 32'h1}, 8'h55, 4'd9, 1'b1, 1'b0, 32'h0,
                     0, 0, 1'b1, 1'b0, 4'hF, 0, 32'h0, 1'b0);
        tbl[6] = mkv({96'h0, 32'h12345678}, 8'h66, 4'd2, 1'b0, 1'b0, 32'h0,
                     0, 3, 1'b0, 1'b1, 4'h1, 0, 32'h0, 1'b0);
        tbl[7] = mkv({96'h0, 32'h77}, 8'h77, 4'd15, 1'b0, 1'b1, 32'h200,
                     T - 1, 0, 1'b0, 1'b0, 4'h0, 1, 32'h200, 1'b0);

        // Reset with a valid head present: nothing may be popped or driven.
        rst = 1'b1; i_wb_valid = 1'b1; i_wb_data = '1; i_wb_tag = 8'hFF; i_wb_dest_reg = 4'hF;
        i_wb_is_vector = 1'b1; i_wb_write_mem = 1'b0; i_wb_mem_addr = '1;
        i_stall = 1'b0; i_mem_ack = 1'b0;
        tick(); tick(); tick();
        #1;
        check("rst_wb_req", o_wb_req, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_rf_we", o_rf_we, 1'b0);
        check("rst_mem_req", o_mem_req, 1'b0);
        check("rst_done", o_done_valid, 1'b0);
        check("rst_mem_error", o_mem_error, 1'b0);
        check("rst_retire", o_retire_count, 16'd0);
        i_wb_valid = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_entry(tbl[i], beats, last_addr, mask, err);
            check($sformatf("row%0d_beats", i), 128'(beats), 128'(tbl[i].exp_beats));
            check($sformatf("row%0d_last_addr", i), last_addr, tbl[i].exp_last);
            check($sformatf("row%0d_mask", i), mask, tbl[i].exp_mask);
            check($sformatf("row%0d_err", i), err, tbl[i].exp_err);
        end

        // Reset during the third beat of a vector memory entry.
        i_wb_valid = 1'b1; i_wb_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0}; i_wb_tag = 8'h99;
        i_wb_dest_reg = 4'd4; i_wb_is_vector = 1'b1; i_wb_write_mem = 1'b1; i_wb_mem_addr = 32'h2000;
        #1;
        check("rstseq_pop", o_wb_req, 1'b1);
        tick();
        i_wb_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            i_mem_ack = 1'b1;
            #1;
            check("rstseq_beat_addr", o_mem_addr, 32'h2000 + 32'(b * 4));
            tick();
        end
        i_mem_ack = 1'b0;
        #1;
        check("rstseq_beat2_addr", o_mem_addr, 32'h2008);
        check("rstseq_beat2_data", o_mem_wdata, 32'hD2);
        rst = 1'b1;
        tick();
        #1;
        check("rstseq_mem_req", o_mem_req, 1'b0);
        check("rstseq_done", o_done_valid, 1'b0);
        check("rstseq_busy", o_busy, 1'b0);
        check("rstseq_retire", o_retire_count, 16'd0);
        check("rstseq_mem_error", o_mem_error, 1'b0);
        rst = 1'b0;
        exp_retire = 0;
        exp_mem_error = 1'b0;
        tick();
        tick();
        #1;
        check("rstseq_no_late_done", o_done_valid, 1'b0);
        check("rstseq_still_idle", o_busy, 1'b0);

        // Random entries against the entry-level model.
        for (int n = 0; n < 40; n++) begin
            rv.data = {$urandom, $urandom, $urandom, $urandom};
            rv.tag = 8'($urandom);
            rv.dest = 4'($urandom);
            rv.vec = 1'($urandom);
            rv.mem = 1'($urandom);
            rv.addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 3) * 4) : $urandom;
            rv.ack_delay = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 3);
            rv.pre_stall = $urandom_range(0, 2);
            rv.hold_valid = 1'($urandom);
            rv.stall_fl = 1'($urandom);
            do_entry(rv, beats, last_addr, mask, err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpu_wb_drain.md
Name: gpu_wb_drain

Overview:
Consumer end of the GPU result writeback buffer. It pops one result entry at a time from the buffer's writeback port and commits it.
- Register results go to the vector register file as a single masked write.
- Memory results go out as one memory-write beat per lane, with an ack handshake.
- Every retired entry emits a completion pulse with its tag and destination register, which the issue-side scoreboard uses to clear hazards.

Parameters:
DATA_WIDTH, 32, lane width in bits
VEC_SIZE, 4, lanes per entry (power of two, 1..8)
TAG_WIDTH, 8, result tag width
ADDR_WIDTH, 32, memory address width
TIMEOUT_CYCLES, 64, cycles allowed per memory beat without ack before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_wb_valid  in  1  buffer head entry valid
i_wb_data  in  DATA_WIDTH x VEC_SIZE  head entry lane data
i_wb_tag  in  TAG_WIDTH  head entry tag
i_wb_dest_reg  in  4  head entry destination register
i_wb_is_vector  in  1  1 = all lanes, 0 = lane 0 only
i_wb_write_mem  in  1  1 = memory write, 0 = register write
i_wb_mem_addr  in  ADDR_WIDTH  memory base address
o_wb_req  out  1  pop strobe to the buffer
i_stall  in  1  inhibit new pops
o_rf_we  out  1  register-file write enable
o_rf_addr  out  4  register-file address
o_rf_lane_mask  out  VEC_SIZE  lane write mask
o_rf_wdata  out  DATA_WIDTH x VEC_SIZE  register-file write data
o_mem_req  out  1  memory write request
o_mem_addr  out  ADDR_WIDTH  beat address
o_mem_wdata  out  DATA_WIDTH  beat data
i_mem_ack  in  1  beat accepted
o_done_valid  out  1  completion pulse
o_done_tag  out  TAG_WIDTH  completed tag
o_done_dest_reg  out  4  completed destination register
o_done_err  out  1  completion was aborted by timeout
o_busy  out  1  entry in flight (state != IDLE)
o_mem_error  out  1  sticky timeout flag
o_retire_count  out  16  retired entries, wraps modulo 2^16

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including o_mem_error and o_retire_count.
  - An entry in flight is dropped with no completion; no further beats are issued.
- States: IDLE, RF_WR, MEM_BEAT, DONE.
- IDLE:
  - o_wb_req = i_wb_valid && !i_stall, combinational.
  - On a pop edge, latch tag, dest_reg, is_vector, write_mem, addr and all lanes into local registers.
  - Next state is RF_WR if write_mem = 0, else MEM_BEAT with beat = 0.
  - o_wb_req is never asserted outside IDLE.
- RF_WR (one cycle):
  - o_rf_we = 1 and o_rf_addr = dest_reg.
  - o_rf_lane_mask = all ones if is_vector, else lane 0 only.
  - o_rf_wdata = latched data.
  - Next state: DONE.
- MEM_BEAT:
  - o_mem_req = 1, o_mem_addr = base + beat*(DATA_WIDTH/8) (truncated to ADDR_WIDTH, wraps), o_mem_wdata = lane[beat].
  - Address and data stay stable until ack.
  - On i_mem_ack: if beat is the last (VEC_SIZE-1 when vector, 0 when scalar) go to DONE; otherwise beat+1 and o_mem_req stays high.
  - Timeout counter clears on entry and on each ack, and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack: set o_mem_error, set the error-pending bit, drop remaining beats, go to DONE.
  - Ack in the same cycle as the timeout wins: no error.
- DONE (one cycle):
  - o_done_valid = 1 with the latched tag and dest_reg, for both register and memory entries.
  - o_done_err = error-pending.
  - o_retire_count increments.
  - Next state: IDLE.
- Latency from pop:
  - Register write: RF write at cycle +1, done at +2.
  - Memory write: done one cycle after the last ack.
- Peak throughput is one register entry per 3 cycles; no back-to-back overlap.
- i_stall only blocks pops; an entry already in flight always completes.
- i_wb_valid deasserting mid-operation has no effect.

Decomposition:
- gpu_wb_pkg holds:
  - the state enum (drain_state_t);
  - the entry struct wb_entry_t (data, tag, dest_reg, is_vector, write_mem, addr);
  - the constant BYTES_PER_LANE = DATA_WIDTH/8.
- The lane beat and timeout logic is the natural sub-module, gpu_wb_mem_seq, with a req/ack-in and done/err-out handshake. Everything else stays flat.

Test Plan:
- Scalar register entry (tag 0x11, dest 5, data lane0 0xDEADBEEF), no stall -> o_wb_req for 1 cycle; next cycle o_rf_we = 1, addr 5, mask 0001, lane0 0xDEADBEEF; next cycle o_done_valid with tag 0x11; o_retire_count = 1.
- Vector memory entry, base 0x1000, lanes 0xA0..0xA3, ack delayed 2 cycles per beat -> beats at 0x1000, 0x1004, 0x1008, 0x100C with matching data; done one cycle after the 4th ack; o_done_err = 0.
- Scalar memory entry, base 0xFFFFFFFC -> exactly one beat at 0xFFFFFFFC; vector entry at the same base -> second beat wraps to 0x00000000.
- Memory entry with ack never asserted, TIMEOUT_CYCLES = 8 -> after 8 cycles of o_mem_req, o_mem_error = 1 and done with o_done_err = 1; a later good entry completes with o_done_err = 0 while o_mem_error stays 1.
- i_stall held high with i_wb_valid = 1 -> no o_wb_req; release -> pop on the first cycle; stall raised during RF_WR -> that entry still completes.
- rst asserted during beat 2 of a vector memory entry -> next cycle o_mem_req = 0, no done pulse, o_busy = 0, counters cleared.
